// File: rtl/vga_mon_pkg.sv
// Shared definitions for the VGA receive-side frame monitor: nominal
// 640x480 timing, FSM states, err_flags bit positions and CRC constants.
package vga_mon_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned V_ACTIVE = 480;

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNCING  = 2'd1,
    ST_LOCKED   = 2'd2
  } mon_state_e;

  localparam int unsigned ERR_W        = 4;
  localparam int unsigned ERR_H_ACTIVE = 0;
  localparam int unsigned ERR_V_ACTIVE = 1;
  localparam int unsigned ERR_LINE_LEN = 2;
  localparam int unsigned ERR_SATURATE = 3;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte CRC-16-CCITT update (poly 0x1021, MSB first), purely combinational.
//   crc_i  : current CRC
//   data_i : byte to absorb, bit 7 first
//   crc_o  : CRC after the byte
module crc16_ccitt_byte
  import vga_mon_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 7; i >= 0; i--) begin
      if (crc_o[15] ^ data_i[i]) crc_o = {crc_o[14:0], 1'b0} ^ CRC_POLY;
      else                       crc_o = {crc_o[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA monitor: rebuilds pixel coordinates from sync/active,
// measures line/frame timing, CRCs the active pixels of each frame and
// tracks lock to the expected mode.
//   clk, rst                  : pixel clock, async active-high reset
//   vga_hs/vs/r/g/b/active    : sampled video stream
//   pix_valid, rx_x, rx_y     : registered pixel qualifier and coordinates
//   probe_x/y -> probe_rgb/valid : single-pixel capture
//   frame_done, meas_*, frame_crc, err_flags : per-frame results
//   locked                    : FSM in LOCKED
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int unsigned EXP_H_ACTIVE    = H_ACTIVE,
  parameter int unsigned EXP_V_ACTIVE    = V_ACTIVE,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned LOCK_FRAMES     = 2,
  parameter int unsigned TIMEOUT         = 1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic [2:0]       vga_r,
  input  logic [2:0]       vga_g,
  input  logic [1:0]       vga_b,
  input  logic             vga_active,
  output logic             pix_valid,
  output logic [CNT_W-1:0] rx_x,
  output logic [CNT_W-1:0] rx_y,
  input  logic [CNT_W-1:0] probe_x,
  input  logic [CNT_W-1:0] probe_y,
  output logic [7:0]       probe_rgb,
  output logic             probe_valid,
  output logic             frame_done,
  output logic [CNT_W-1:0] meas_h_total,
  output logic [CNT_W-1:0] meas_h_active,
  output logic [CNT_W-1:0] meas_v_total,
  output logic [CNT_W-1:0] meas_v_active,
  output logic [15:0]      frame_crc,
  output logic [ERR_W-1:0] err_flags,
  output logic             locked
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);

  logic hs_prev_q, vs_prev_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, h_cnt_q, h_cnt_d, h_last_q, h_last_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d, href_q, href_d;
  logic href_set_q, href_set_d, incons_q, incons_d, sat_q, sat_d;
  logic [15:0] crc_q, crc_d, crc_base_c, crc_next_c;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GOOD_W-1:0] good_q, good_d;
  mon_state_e state_q, state_d;

  logic pix_valid_q, pix_valid_d, probe_valid_q, probe_valid_d;
  logic frame_done_q, frame_done_d, locked_q, locked_d;
  logic [CNT_W-1:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic [CNT_W-1:0] mh_tot_q, mh_tot_d, mh_act_q, mh_act_d;
  logic [CNT_W-1:0] mv_tot_q, mv_tot_d, mv_act_q, mv_act_d;
  logic [7:0] probe_rgb_q, probe_rgb_d;
  logic [15:0] fcrc_q, fcrc_d;
  logic [ERR_W-1:0] err_q, err_d, err_c;

  logic hs_asrt_c, vs_asrt_c, hs_edge_c, vs_edge_c, frame_end_c, tmo_hit_c;
  logic [7:0] pix_c;

  assign hs_asrt_c   = SYNC_ACTIVE_LOW ? ~vga_hs : vga_hs;
  assign vs_asrt_c   = SYNC_ACTIVE_LOW ? ~vga_vs : vga_vs;
  assign hs_edge_c   = hs_asrt_c & ~hs_prev_q;
  assign vs_edge_c   = vs_asrt_c & ~vs_prev_q;
  assign frame_end_c = vs_edge_c & (state_q != ST_UNLOCKED);
  assign tmo_hit_c   = ~vs_edge_c & (tmo_q == TMO_W'(TIMEOUT - 1));
  assign pix_c       = {vga_r, vga_g, vga_b};
  // A sample coinciding with a vsync edge starts the new frame's CRC.
  assign crc_base_c  = vs_edge_c ? CRC_INIT : crc_q;

  crc16_ccitt_byte u_crc (
    .crc_i  (crc_base_c),
    .data_i (pix_c),
    .crc_o  (crc_next_c)
  );

  // Datapath: close the line, then the frame, then absorb this cycle's sample.
  always_comb begin
    x_d = x_q; y_d = y_q; v_cnt_d = v_cnt_q; h_last_d = h_last_q;
    href_d = href_q; href_set_d = href_set_q; incons_d = incons_q; sat_d = sat_q;
    crc_d = crc_base_c;
    pix_valid_d = vga_active; rx_x_d = rx_x_q; rx_y_d = rx_y_q;
    probe_valid_d = 1'b0; probe_rgb_d = probe_rgb_q;
    frame_done_d = frame_end_c;
    mh_tot_d = mh_tot_q; mh_act_d = mh_act_q; mv_tot_d = mv_tot_q; mv_act_d = mv_act_q;
    fcrc_d = fcrc_q; err_d = err_q;
    h_cnt_d = sat_inc(h_cnt_q);
    if (h_cnt_q == CNT_MAX) sat_d = 1'b1;

    // x_q is nonzero exactly when the line held an active pixel.
    if (hs_edge_c) begin
      h_last_d = h_cnt_q;
      h_cnt_d  = CNT_W'(1);
      x_d      = '0;
      v_cnt_d  = sat_inc(v_cnt_q);
      if (v_cnt_q == CNT_MAX) sat_d = 1'b1;
      if (x_q != '0) begin
        y_d = sat_inc(y_q);
        if (y_q == CNT_MAX) sat_d = 1'b1;
        if (!href_set_q) begin
          href_d     = x_q;
          href_set_d = 1'b1;
        end else if (x_q != href_q) begin
          incons_d = 1'b1;
        end
      end
    end

    err_c = '0;
    err_c[ERR_H_ACTIVE] = (href_d != CNT_W'(EXP_H_ACTIVE));
    err_c[ERR_V_ACTIVE] = (y_d != CNT_W'(EXP_V_ACTIVE));
    err_c[ERR_LINE_LEN] = incons_d;
    err_c[ERR_SATURATE] = sat_d;

    if (frame_end_c) begin
      mh_tot_d = h_last_d;
      mh_act_d = href_d;
      mv_tot_d = v_cnt_d;
      mv_act_d = y_d;
      fcrc_d   = crc_q;
      err_d    = err_c;
    end
    if (vs_edge_c) begin
      y_d = '0; v_cnt_d = '0; href_d = '0; href_set_d = 1'b0;
      incons_d = 1'b0; sat_d = 1'b0;
    end

    if (vga_active) begin
      rx_x_d = x_d;
      rx_y_d = y_d;
      crc_d  = crc_next_c;
      if (x_d == CNT_MAX) sat_d = 1'b1;
      if (x_d == probe_x && y_d == probe_y) begin
        probe_valid_d = 1'b1;
        probe_rgb_d   = pix_c;
      end
      x_d = sat_inc(x_d);
    end
  end

  // Lock FSM next state; timeout overrides everything.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    tmo_d   = vs_edge_c ? '0 : ((tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1);
    case (state_q)
      ST_UNLOCKED: begin
        if (vs_edge_c) begin
          state_d = ST_SYNCING;
          good_d  = '0;
        end
      end
      ST_SYNCING: begin
        if (frame_end_c) begin
          if (err_c != '0) begin
            good_d = '0;
          end else if (32'(good_q) + 32'd1 >= LOCK_FRAMES) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (frame_end_c && err_c != '0) begin
          state_d = ST_SYNCING;
          good_d  = '0;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
    if (tmo_hit_c) begin
      state_d = ST_UNLOCKED;
      good_d  = '0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_prev_q <= 1'b0; vs_prev_q <= 1'b0;
      x_q <= '0; y_q <= '0; h_cnt_q <= '0; h_last_q <= '0; v_cnt_q <= '0;
      href_q <= '0; href_set_q <= 1'b0; incons_q <= 1'b0; sat_q <= 1'b0;
      crc_q <= CRC_INIT; tmo_q <= '0; good_q <= '0; state_q <= ST_UNLOCKED;
      pix_valid_q <= 1'b0; rx_x_q <= '0; rx_y_q <= '0;
      probe_valid_q <= 1'b0; probe_rgb_q <= '0; frame_done_q <= 1'b0;
      mh_tot_q <= '0; mh_act_q <= '0; mv_tot_q <= '0; mv_act_q <= '0;
      fcrc_q <= '0; err_q <= '0; locked_q <= 1'b0;
    end else begin
      hs_prev_q <= hs_asrt_c; vs_prev_q <= vs_asrt_c;
      x_q <= x_d; y_q <= y_d; h_cnt_q <= h_cnt_d; h_last_q <= h_last_d; v_cnt_q <= v_cnt_d;
      href_q <= href_d; href_set_q <= href_set_d; incons_q <= incons_d; sat_q <= sat_d;
      crc_q <= crc_d; tmo_q <= tmo_d; good_q <= good_d; state_q <= state_d;
      pix_valid_q <= pix_valid_d; rx_x_q <= rx_x_d; rx_y_q <= rx_y_d;
      probe_valid_q <= probe_valid_d; probe_rgb_q <= probe_rgb_d; frame_done_q <= frame_done_d;
      mh_tot_q <= mh_tot_d; mh_act_q <= mh_act_d; mv_tot_q <= mv_tot_d; mv_act_q <= mv_act_d;
      fcrc_q <= fcrc_d; err_q <= err_d; locked_q <= locked_d;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign rx_x          = rx_x_q;
  assign rx_y          = rx_y_q;
  assign probe_rgb     = probe_rgb_q;
  assign probe_valid   = probe_valid_q;
  assign frame_done    = frame_done_q;
  assign meas_h_total  = mh_tot_q;
  assign meas_h_active = mh_act_q;
  assign meas_v_total  = mv_tot_q;
  assign meas_v_active = mv_act_q;
  assign frame_crc     = fcrc_q;
  assign err_flags     = err_q;
  assign locked        = locked_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor using a scaled-down video mode
// (24 clocks/line with 16 active, 10 lines/frame with 6 active) so that
// many frames fit in a short run.
module tb_vga_frame_monitor;

  localparam int H_TOT = 24;
  localparam int H_ACT = 16;
  localparam int V_TOT = 10;
  localparam int V_ACT = 6;
  localparam int TMO   = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vga_hs = 1'b1, vga_vs = 1'b1, vga_active = 1'b0;
  logic [2:0] vga_r = '0, vga_g = '0;
  logic [1:0] vga_b = '0;
  logic [9:0] probe_x = 10'd5, probe_y = 10'd3;
  logic       pix_valid, probe_valid, frame_done, locked;
  logic [9:0] rx_x, rx_y, meas_h_total, meas_h_active, meas_v_total, meas_v_active;
  logic [7:0] probe_rgb;
  logic [15:0] frame_crc;
  logic [3:0] err_flags;

  vga_frame_monitor #(
    .EXP_H_ACTIVE(H_ACT), .EXP_V_ACTIVE(V_ACT), .SYNC_ACTIVE_LOW(1'b1),
    .LOCK_FRAMES(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_active(vga_active),
    .pix_valid(pix_valid), .rx_x(rx_x), .rx_y(rx_y),
    .probe_x(probe_x), .probe_y(probe_y), .probe_rgb(probe_rgb), .probe_valid(probe_valid),
    .frame_done(frame_done), .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
    .meas_v_total(meas_v_total), .meas_v_active(meas_v_active),
    .frame_crc(frame_crc), .err_flags(err_flags), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Event monitor: counts frame_done / probe_valid pulses and keeps the probe snapshot.
  int fd_cnt = 0;
  int pv_cnt = 0;
  logic [7:0] pv_rgb = '0;
  logic [9:0] pv_x = '0, pv_y = '0;
  logic pv_pix = 1'b0;
  always @(negedge clk) begin
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (probe_valid) begin
      pv_cnt = pv_cnt + 1;
      pv_rgb = probe_rgb;
      pv_x   = rx_x;
      pv_y   = rx_y;
      pv_pix = pix_valid;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC-16-CCITT (byte xored into the high half, then 8 shifts).
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  logic [15:0] model_crc = 16'hFFFF;
  logic [15:0] prev_crc  = 16'hFFFF;

  task automatic drive(input logic hs, input logic vs, input logic act, input logic [7:0] px);
    @(negedge clk);
    vga_hs = hs; vga_vs = vs; vga_active = act;
    {vga_r, vga_g, vga_b} = px;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic idle_lines(input int n);
    for (int l = 0; l < n; l++)
      for (int h = 0; h < H_TOT; h++) drive(h >= 2, 1'b1, 1'b0, 8'h00);
  endtask

  // kind 0: all 0xFF; kind 1: single 0x00 pixel at (0,0); kind 2: 0x00 with 0xA5 at (5,3).
  // short_row gets one pixel fewer; abort_v stops the frame at that line.
  task automatic send_frame(input int kind, input int short_row, input int abort_v);
    int row, col, len;
    logic a;
    logic [7:0] px;
    prev_crc  = model_crc;
    model_crc = 16'hFFFF;
    for (int v = 0; v < V_TOT; v++) begin
      if (v == abort_v) return;
      for (int h = 0; h < H_TOT; h++) begin
        row = v - 2;
        col = h - 4;
        len = (row == short_row) ? H_ACT - 1 : H_ACT;
        if (kind == 1) a = (row == 0 && col == 0);
        else           a = (row >= 0 && row < V_ACT && col >= 0 && col < len);
        if (kind == 0)                              px = 8'hFF;
        else if (kind == 2 && row == 3 && col == 5) px = 8'hA5;
        else                                        px = 8'h00;
        if (a) model_crc = crc_model(model_crc, px);
        drive(h >= 2, v >= 2, a, px);
      end
    end
  endtask

  task automatic check_meas(input string tag, input int ht, input int ha, input int vt, input int va);
    check_eq({tag, ".h_total"},  32'(meas_h_total),  32'(ht));
    check_eq({tag, ".h_active"}, 32'(meas_h_active), 32'(ha));
    check_eq({tag, ".v_total"},  32'(meas_v_total),  32'(vt));
    check_eq({tag, ".v_active"}, 32'(meas_v_active), 32'(va));
  endtask

  int fd_base;
  int pv_base;

  initial begin
    // Reset state
    idle(3);
    check_eq("rst.locked",     32'(locked), 0);
    check_eq("rst.frame_done", 32'(frame_done), 0);
    check_eq("rst.pix_valid",  32'(pix_valid), 0);
    check_eq("rst.frame_crc",  32'(frame_crc), 0);
    check_eq("rst.err",        32'(err_flags), 0);
    @(negedge clk); rst = 1'b0;
    idle(4);

    // Ideal stream: lock on the second frame_done
    send_frame(0, -1, -1);
    check_eq("ideal.no_done_first", 32'(fd_cnt), 0);
    check_eq("ideal.probe_rgb",     32'(pv_rgb), 32'h00FF);
    send_frame(0, -1, -1);
    check_eq("ideal.fd1", 32'(fd_cnt), 1);
    check_meas("ideal", H_TOT, H_ACT, V_TOT, V_ACT);
    check_eq("ideal.err",     32'(err_flags), 0);
    check_eq("ideal.crc",     32'(frame_crc), 32'(prev_crc));
    check_eq("ideal.locked1", 32'(locked), 0);
    send_frame(0, -1, -1);
    check_eq("ideal.locked2", 32'(locked), 1);

    // One 0x00 pixel per frame
    send_frame(1, -1, -1);
    check_eq("single.still_locked", 32'(locked), 1);
    send_frame(1, -1, -1);
    check_eq("single.crc",    32'(frame_crc), 32'hE1F0);
    check_eq("single.err",    32'(err_flags), 32'h3);
    check_meas("single", H_TOT, 1, V_TOT, 1);
    check_eq("single.locked", 32'(locked), 0);

    // One short line, then relock after two clean frames
    send_frame(0, 3, -1);
    check_eq("short.prev_err",  32'(err_flags), 32'h3);
    send_frame(0, -1, -1);
    check_eq("short.err",       32'(err_flags), 32'h4);
    check_eq("short.h_active",  32'(meas_h_active), H_ACT);
    check_eq("short.crc",       32'(frame_crc), 32'(prev_crc));
    check_eq("short.locked",    32'(locked), 0);
    send_frame(0, -1, -1);
    check_eq("relock.err",      32'(err_flags), 0);
    check_eq("relock.locked1",  32'(locked), 0);
    send_frame(0, -1, -1);
    check_eq("relock.locked2",  32'(locked), 1);

    // Reset in the middle of a frame
    send_frame(0, -1, 5);
    @(negedge clk);
    vga_hs = 1'b1; vga_vs = 1'b1; vga_active = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst.locked",   32'(locked), 0);
    check_eq("midrst.h_total",  32'(meas_h_total), 0);
    check_eq("midrst.v_active", 32'(meas_v_active), 0);
    check_eq("midrst.crc",      32'(frame_crc), 0);
    check_eq("midrst.probe",    32'(probe_rgb), 0);
    check_eq("midrst.rx_x",     32'(rx_x), 0);
    idle(2);
    @(negedge clk); rst = 1'b0;
    idle(3);
    fd_base = fd_cnt;
    send_frame(0, -1, -1);
    check_eq("midrst.no_done", 32'(fd_cnt - fd_base), 0);
    send_frame(0, -1, -1);
    check_eq("midrst.one_done", 32'(fd_cnt - fd_base), 1);
    check_meas("postrst", H_TOT, H_ACT, V_TOT, V_ACT);
    check_eq("postrst.crc", 32'(frame_crc), 32'(prev_crc));

    // Vsync timeout while locked
    send_frame(0, -1, -1);
    check_eq("tmo.locked_before", 32'(locked), 1);
    fd_base = fd_cnt;
    idle_lines(90);
    check_eq("tmo.locked_after", 32'(locked), 0);
    send_frame(0, -1, -1);
    check_eq("tmo.no_done", 32'(fd_cnt - fd_base), 0);
    send_frame(0, -1, -1);
    check_eq("tmo.syncing_done", 32'(fd_cnt - fd_base), 1);
    check_eq("tmo.err",    32'(err_flags), 0);
    check_eq("tmo.locked", 32'(locked), 0);

    // Probe pixel 0xA5 at (5,3)
    pv_base = pv_cnt;
    send_frame(2, -1, -1);
    check_eq("probe.locked", 32'(locked), 1);
    check_eq("probe.cnt1",   32'(pv_cnt - pv_base), 1);
    check_eq("probe.rgb",    32'(pv_rgb), 32'h00A5);
    check_eq("probe.x",      32'(pv_x), 5);
    check_eq("probe.y",      32'(pv_y), 3);
    check_eq("probe.pix",    32'(pv_pix), 1);
    send_frame(2, -1, -1);
    check_eq("probe.cnt2",   32'(pv_cnt - pv_base), 2);
    check_eq("probe.crc",    32'(frame_crc), 32'(prev_crc));
    check_eq("probe.err",    32'(err_flags), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
